// File: rtl/l2_fill_unit.sv
// L2 miss fill unit: in-order miss queue feeding a single-outstanding DRAM fill FSM.
// Optional macro L2_FILL_MERGE_EN drops accepted misses whose line is already queued or in flight.
module l2_fill_unit #(
  parameter int ADDR_W     = 32,
  parameter int LINE_LOG   = 7,
  parameter int DRAM_DELAY = 400,
  parameter int DEPTH_LOG  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 miss_valid,
  input  logic [ADDR_W-1:0]    miss_addr,
  output logic                 miss_ready,
  output logic                 fill_write,
  output logic [ADDR_W-1:0]    fill_addr,
  output logic                 busy,
  output logic [DEPTH_LOG:0]   pending
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam int CNT_W = $clog2(DRAM_DELAY + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << LINE_LOG;

  typedef enum logic [1:0] {IDLE, WAIT, FILL} state_t;

  state_t                 state;
  logic [ADDR_W-1:0]      queue [DEPTH];
  logic [DEPTH_LOG-1:0]   head;
  logic [DEPTH_LOG-1:0]   tail;
  logic [DEPTH_LOG:0]     count;
  logic [ADDR_W-1:0]      inflight;
  logic [CNT_W-1:0]       cnt;
  logic                   fill_q;

  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   merged;
  logic [ADDR_W-1:0]      line_addr;

  assign line_addr  = miss_addr & LINE_MASK;
  assign full       = (count == (DEPTH_LOG+1)'(DEPTH));
  assign miss_ready = !full && !stall && !reset;
  assign push       = miss_valid && miss_ready && !merged;
  assign pop        = (state == IDLE) && (count != '0) && !stall && !reset;

`ifdef L2_FILL_MERGE_EN
  logic [DEPTH-1:0] valid_q;

  // A miss to a line already queued or being fetched rides on that fill.
  always_comb begin
    merged = (state != IDLE) && (inflight == line_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (queue[i] == line_addr)) merged = 1'b1;
    end
  end
`else
  assign merged = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      cnt      <= '0;
      fill_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) queue[i] <= '0;
`ifdef L2_FILL_MERGE_EN
      valid_q  <= '0;
`endif
    end else if (!stall) begin
      if (push) begin
        queue[tail] <= line_addr;
        tail        <= tail + DEPTH_LOG'(1);
`ifdef L2_FILL_MERGE_EN
        valid_q[tail] <= 1'b1;
`endif
      end
      if (pop) begin
        head <= head + DEPTH_LOG'(1);
`ifdef L2_FILL_MERGE_EN
        valid_q[head] <= 1'b0;
`endif
      end
      case ({push, pop})
        2'b10:   count <= count + (DEPTH_LOG+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG+1)'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            inflight <= queue[head];
            cnt      <= CNT_W'(DRAM_DELAY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state  <= FILL;
            fill_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        FILL: begin
          state  <= IDLE;
          fill_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          fill_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are forced quiet during the reset cycle itself, not only after it.
  assign fill_write = fill_q && !reset;
  assign fill_addr  = reset ? '0 : inflight;
  assign busy       = !reset && ((count != '0) || (state != IDLE));
  assign pending    = reset ? '0 : count + {{DEPTH_LOG{1'b0}}, (state != IDLE)};

endmodule

// File: tb/tb_l2_fill_unit.sv
// Directed bench for l2_fill_unit with DRAM_DELAY=4, DEPTH_LOG=2.
module tb_l2_fill_unit;

  localparam int ADDR_W = 32;
  localparam int DL     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              miss_valid;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;
  logic              fill_write;
  logic [ADDR_W-1:0] fill_addr;
  logic              busy;
  logic [2:0]        pending;

  l2_fill_unit #(.ADDR_W(ADDR_W), .LINE_LOG(7), .DRAM_DELAY(DL), .DEPTH_LOG(2)) dut (
    .clk(clk), .reset(reset), .stall(stall), .miss_valid(miss_valid),
    .miss_addr(miss_addr), .miss_ready(miss_ready), .fill_write(fill_write),
    .fill_addr(fill_addr), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fw_cycles = 0;
  logic [31:0] fill_log [$];
  int          fill_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Unstalled fill writes are the ones that land in the tag array.
  always @(negedge clk) begin
    if (fill_write) begin
      fw_cycles++;
      if (!stall) begin
        fill_log.push_back(fill_addr);
        fill_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push_miss(input logic [31:0] addr, output int t_acc);
    int k;
    miss_valid = 1'b1;
    miss_addr  = addr;
    t_acc = -1;
    for (k = 0; k < 100; k++) begin
      settle();
      if (miss_ready) begin
        t_acc = cyc;
        break;
      end
      next();
    end
    if (t_acc < 0) check("push_timeout", 0, 1);
    next();
    miss_valid = 1'b0;
  endtask

  task automatic wait_fills(input int n, input int budget);
    for (int k = 0; k < budget && fill_log.size() < n; k++) next();
    check("fills_seen", fill_log.size(), n);
  endtask

  task automatic clear_log();
    fill_log.delete();
    fill_cyc.delete();
  endtask

  int t0, t1, tq[8], fw0;
  logic [31:0] a8[8];

  initial begin
    reset = 1'b1; stall = 1'b0; miss_valid = 1'b0; miss_addr = '0;

    // Reset state, with a request held to confirm it is refused.
    next(); next();
    miss_valid = 1'b1; miss_addr = 32'h0000_1234;
    settle();
    check("rst_ready",   miss_ready, 0);
    check("rst_fw",      fill_write, 0);
    check("rst_faddr",   fill_addr,  0);
    check("rst_busy",    busy,       0);
    check("rst_pending", pending,    0);
    miss_valid = 1'b0;
    next();
    reset = 1'b0;
    next(); next(); next(); next(); next();

    // Single miss: latency DRAM_DELAY+2, aligned address.
    clear_log();
    fw0 = fw_cycles;
    push_miss(32'h0000_1234, t0);
    settle();
    check("single_pend_a", pending, 1);
    wait_fills(1, 40);
    if (fill_log.size() >= 1) begin
      check("single_lat",  fill_cyc[0] - t0, DL + 2);
      check("single_addr", fill_log[0], 32'h0000_1200);
    end
    next(); settle();
    check("single_pend_z", pending, 0);
    check("single_busy",   busy, 0);
    check("single_fwcnt",  fw_cycles - fw0, 1);

    // Five back-to-back misses on distinct lines.
    clear_log();
    for (int i = 0; i < 5; i++) begin
      miss_valid = 1'b1;
      miss_addr  = 32'h0000_1000 * (i + 1) + 32'h11;
      settle();
      check("b2b_ready", miss_ready, 1);
      if (i == 0) t0 = cyc;
      next();
    end
    miss_valid = 1'b0;
    settle();
    check("b2b_full_ready", miss_ready, 0);
    check("b2b_pend_peak",  pending, 5);
    wait_fills(5, 100);
    for (int i = 0; i < 5 && i < fill_log.size(); i++) begin
      check("b2b_addr", fill_log[i], 32'h0000_1000 * (i + 1));
      if (i > 0) check("b2b_space", fill_cyc[i] - fill_cyc[i-1], 6);
    end
    next(); next();

    // Stall held for three cycles during FILL.
    clear_log();
    fw0 = fw_cycles;
    push_miss(32'h0000_3385, t0);
    while (cyc < t0 + DL + 2) next();
    stall = 1'b1;
    settle();
    check("stall_fw0", fill_write, 1);
    check("stall_ready", miss_ready, 0);
    next(); settle();
    check("stall_fw1", fill_write, 1);
    check("stall_addr1", fill_addr, 32'h0000_3380);
    next(); settle();
    check("stall_fw2", fill_write, 1);
    check("stall_addr2", fill_addr, 32'h0000_3380);
    next();
    stall = 1'b0;
    settle();
    check("stall_fw3", fill_write, 1);
    next(); settle();
    check("stall_fw_end", fill_write, 0);
    check("stall_fwcnt",  fw_cycles - fw0, 4);
    check("stall_writes", fill_log.size(), 1);
    if (fill_log.size() >= 1) check("stall_wcyc", fill_cyc[0] - t0, DL + 5);

    // Reset pulsed during WAIT aborts the fill.
    clear_log();
    fw0 = fw_cycles;
    push_miss(32'h0000_7000, t0);
    while (cyc < t0 + 3) next();
    reset = 1'b1;
    settle();
    check("rwait_ready", miss_ready, 0);
    next();
    reset = 1'b0;
    settle();
    check("rwait_fw",    fill_write, 0);
    check("rwait_faddr", fill_addr,  0);
    check("rwait_busy",  busy,       0);
    check("rwait_pend",  pending,    0);
    for (int k = 0; k < 15; k++) next();
    check("rwait_nofill", fw_cycles - fw0, 0);

    // Same-line misses: merged or duplicated depending on the build.
    clear_log();
    miss_valid = 1'b1; miss_addr = 32'h0000_0400;
    next();
    miss_addr = 32'h0000_047F;
    next();
    miss_valid = 1'b0;
    settle();
`ifdef L2_FILL_MERGE_EN
    check("merge_pend", pending, 1);
    wait_fills(1, 40);
    for (int k = 0; k < 20; k++) next();
    check("merge_nfill", fill_log.size(), 1);
`else
    check("dup_pend", pending, 2);
    wait_fills(2, 40);
    for (int k = 0; k < 20; k++) next();
    check("dup_nfill", fill_log.size(), 2);
    if (fill_log.size() >= 2) check("dup_addr1", fill_log[1], 32'h0000_0400);
`endif
    if (fill_log.size() >= 1) check("same_addr0", fill_log[0], 32'h0000_0400);

    // Eight pushes interleaved with pops, wrapping the pointers twice.
    clear_log();
    for (int i = 0; i < 8; i++) begin
      a8[i] = 32'h0001_0000 + 32'h80 * (i * 3 + 1);
      push_miss(a8[i] | 32'h5, t1);
      tq[i] = t1;
      next();
    end
    wait_fills(8, 200);
    for (int i = 0; i < 8 && i < fill_log.size(); i++) check("wrap_order", fill_log[i], a8[i]);
    next(); next(); settle();
    check("wrap_idle_pend", pending, 0);
    check("wrap_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
